// File: rtl/empty_ptr_fifo_if.sv
// Push/pop bundle for the free-address allocator.
// slave  : allocator side (takes push/pop strobes, drives head address and status)
// master : insert/delete engine side
// Ports:
//   add_empty_ptr_i / add_empty_ptr_en_i : address being freed, push strobe
//   empty_addr_o / empty_addr_val_o      : head free address and its valid
//   empty_addr_rd_ack_i                  : pop strobe
//   free_cnt_o                           : number of free addresses held (0..N)
//   init_done_o                          : initialisation sweep finished
//   overflow_err_o / dbl_free_err_o      : sticky error flags
interface empty_ptr_fifo_if #(
    parameter int A_WIDTH = 3
);
    logic [A_WIDTH-1:0] add_empty_ptr_i;
    logic               add_empty_ptr_en_i;
    logic [A_WIDTH-1:0] empty_addr_o;
    logic               empty_addr_val_o;
    logic               empty_addr_rd_ack_i;
    logic [A_WIDTH:0]   free_cnt_o;
    logic               init_done_o;
    logic               overflow_err_o;
    logic               dbl_free_err_o;

    modport slave (
        input  add_empty_ptr_i,
        input  add_empty_ptr_en_i,
        input  empty_addr_rd_ack_i,
        output empty_addr_o,
        output empty_addr_val_o,
        output free_cnt_o,
        output init_done_o,
        output overflow_err_o,
        output dbl_free_err_o
    );

    modport master (
        output add_empty_ptr_i,
        output add_empty_ptr_en_i,
        output empty_addr_rd_ack_i,
        input  empty_addr_o,
        input  empty_addr_val_o,
        input  free_cnt_o,
        input  init_done_o,
        input  overflow_err_o,
        input  dbl_free_err_o
    );
endinterface

// File: rtl/empty_ptr_fifo.sv
// Free-address allocator for the hash-table data RAM.
// Holds every data-table address not linked into a bucket chain; hands them
// out on pop (first-word fall-through) and takes released ones back on push.
// After any reset (rst_i or srst_i) it sweeps all N addresses into the queue.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   srst_i : soft reset, identical effect to rst_i
//   bus    : push/pop/status bundle (empty_ptr_fifo_if.slave)
//
// state  | meaning
// -------+-----------------------------------------------------------
// INIT   | writing mem[i]=i, one entry per cycle; push/pop ignored
// READY  | normal allocate (pop) / release (push) operation
module empty_ptr_fifo #(
    parameter int TABLE_ADDR_WIDTH = 3,
    parameter int A_WIDTH          = TABLE_ADDR_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              srst_i,
    empty_ptr_fifo_if.slave   bus
);
    localparam int N = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0]   CNT_FULL = {1'b1, {A_WIDTH{1'b0}}};
    localparam logic [A_WIDTH:0]   ONE_C    = (A_WIDTH+1)'(1);
    localparam logic [A_WIDTH-1:0] ONE_A    = A_WIDTH'(1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH:0]   cnt_q, cnt_d;
    logic [N-1:0]       free_mask_q, free_mask_d;
    logic               ovf_q, ovf_d;
    logic               dbl_q, dbl_d;
    logic [A_WIDTH-1:0] mem_q [N];

    logic               mem_we;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [A_WIDTH-1:0] mem_wdata;
    logic               val;
    logic               pop;
    logic               push_ok;
    logic               dbl_hit;
    logic               ovf_hit;
    logic               soft_or_hard_rst;
    logic [A_WIDTH-1:0] head;

    assign soft_or_hard_rst = rst_i | srst_i;
    assign head             = mem_q[rd_ptr_q];
    assign val              = (state_q == ST_READY) && (cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        free_mask_d = free_mask_q;
        ovf_d       = ovf_q;
        dbl_d       = dbl_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = bus.add_empty_ptr_i;
        pop         = 1'b0;
        push_ok     = 1'b0;
        dbl_hit     = 1'b0;
        ovf_hit     = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we                  = 1'b1;
                mem_waddr               = init_cnt_q;
                mem_wdata               = init_cnt_q;
                free_mask_d[init_cnt_q] = 1'b1;
                init_cnt_d              = init_cnt_q + ONE_A;
                if (&init_cnt_q) begin
                    state_d  = ST_READY;
                    cnt_d    = CNT_FULL;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                pop = bus.empty_addr_rd_ack_i && val;
                // Releasing the address that is being handed out this very
                // cycle is a legitimate recycle, not a double free.
                dbl_hit = bus.add_empty_ptr_en_i
                          && free_mask_q[bus.add_empty_ptr_i]
                          && !(pop && (head == bus.add_empty_ptr_i));
                ovf_hit = bus.add_empty_ptr_en_i && !dbl_hit
                          && (cnt_q == CNT_FULL) && !pop;
                push_ok = bus.add_empty_ptr_en_i && !dbl_hit && !ovf_hit;

                if (pop) begin
                    rd_ptr_d          = rd_ptr_q + ONE_A;
                    free_mask_d[head] = 1'b0;
                end
                // Applied after the pop clear so a same-address pop+push leaves the bit set.
                if (push_ok) begin
                    mem_we                               = 1'b1;
                    wr_ptr_d                             = wr_ptr_q + ONE_A;
                    free_mask_d[bus.add_empty_ptr_i]     = 1'b1;
                end
                if (push_ok && !pop)
                    cnt_d = cnt_q + ONE_C;
                else if (pop && !push_ok)
                    cnt_d = cnt_q - ONE_C;

                ovf_d = ovf_q | ovf_hit;
                dbl_d = dbl_q | dbl_hit;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_or_hard_rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            free_mask_q <= '0;
            ovf_q       <= 1'b0;
            dbl_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            free_mask_q <= free_mask_d;
            ovf_q       <= ovf_d;
            dbl_q       <= dbl_d;
        end
    end

    // Contents need no reset: the INIT sweep rewrites every entry.
    always_ff @(posedge clk_i) begin
        if (mem_we && !soft_or_hard_rst)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.empty_addr_o     = head;
    assign bus.empty_addr_val_o = val;
    assign bus.free_cnt_o       = cnt_q;
    assign bus.init_done_o      = (state_q == ST_READY);
    assign bus.overflow_err_o   = ovf_q;
    assign bus.dbl_free_err_o   = dbl_q;
endmodule

// File: tb/tb_empty_ptr_fifo.sv
module tb_empty_ptr_fifo;
    localparam int AW = 3;
    localparam int N  = 8;

    logic clk_i = 1'b0;
    logic rst_i;
    logic srst_i;

    empty_ptr_fifo_if #(.A_WIDTH(AW)) bus();

    empty_ptr_fifo #(.A_WIDTH(AW)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .srst_i (srst_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string          name;
        logic           rst;
        logic           srst;
        logic           en;
        logic [AW-1:0]  addr;
        logic           ack;
        logic           e_val;
        logic [AW-1:0]  e_addr;
        int             e_cnt;
        logic           e_done;
        logic           e_dbl;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rst, input logic srst,
                       input logic en, input int addr, input logic ack,
                       input logic e_val, input int e_addr, input int e_cnt,
                       input logic e_done, input logic e_dbl);
        vec_t v;
        v.name = name; v.rst = rst; v.srst = srst; v.en = en;
        v.addr = AW'(addr); v.ack = ack; v.e_val = e_val;
        v.e_addr = AW'(e_addr); v.e_cnt = e_cnt; v.e_done = e_done;
        v.e_dbl = e_dbl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic srst, input logic en,
                         input logic [AW-1:0] addr, input logic ack);
        rst_i                   = rst;
        srst_i                  = srst;
        bus.add_empty_ptr_en_i  = en;
        bus.add_empty_ptr_i     = addr;
        bus.empty_addr_rd_ack_i = ack;
    endtask

    // model for the random phase
    logic [AW-1:0] sb[$];
    logic [N-1:0]  m_mask;
    logic          m_dbl;
    logic          m_ovf;

    initial begin
        int heads[4];
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // power-up reset and init sweep
        add("rst", 1,0, 0,0,0, 0,0,0,0,0);
        for (int i = 1; i < N; i++) add("init_wait", 0,0, 0,0,0, 0,0,0,0,0);
        add("init_end", 0,0, 0,0,0, 1,0,8,1,0);
        // full queue: every address is already free
        add("dbl_full", 0,0, 1,3,0, 1,0,8,1,1);
        add("srst_clr", 0,1, 0,0,0, 0,0,0,0,0);
        for (int i = 1; i < N; i++) add("reinit_wait", 0,0, 0,0,0, 0,0,0,0,0);
        add("reinit_end", 0,0, 0,0,0, 1,0,8,1,0);
        // drain back-to-back
        for (int i = 1; i <= N; i++)
            add("pop_seq", 0,0, 0,0,1, (i < N), i % N, N - i, 1, 0);
        add("pop_empty", 0,0, 0,0,1, 0,0,0,1,0);
        // zero-bubble refill
        add("push5", 0,0, 1,5,0, 1,5,1,1,0);
        add("push2", 0,0, 1,2,0, 1,5,2,1,0);
        add("pop5",  0,0, 0,0,1, 1,2,1,1,0);
        add("pop2",  0,0, 0,0,1, 0,0,0,1,0);
        // cnt=4 then simultaneous push/pop
        for (int i = 0; i < 4; i++) add("fill", 0,0, 1,i,0, 1,0,i+1,1,0);
        add("push_pop", 0,0, 1,6,1, 1,1,4,1,0);
        add("push0_ok", 0,0, 1,0,0, 1,1,5,1,0);
        heads = '{2, 3, 6, 0};
        for (int i = 0; i < 4; i++) add("tail_order", 0,0, 0,0,1, 1,heads[i],4-i,1,0);
        add("tail_empty", 0,0, 0,0,1, 0,0,0,1,0);
        // srst in the middle of INIT, with traffic during INIT
        add("srst", 0,1, 0,0,0, 0,0,0,0,0);
        for (int i = 1; i < 4; i++) add("init_traffic", 0,0, 1,7,1, 0,0,0,0,0);
        add("srst_mid", 0,1, 1,7,1, 0,0,0,0,0);
        for (int i = 1; i < N; i++) add("init_traffic2", 0,0, 1,7,1, 0,0,0,0,0);
        add("init_end3", 0,0, 1,7,1, 1,0,8,1,0);
        // full with simultaneous pop+push of the head
        add("full_pp", 0,0, 1,0,1, 1,1,8,1,0);
        for (int k = 1; k <= 7; k++)
            add("full_pp_drain", 0,0, 0,0,1, 1,(k < 7) ? k + 1 : 0, 8 - k, 1, 0);
        add("dbl0", 0,0, 1,0,0, 1,0,1,1,1);

        @(posedge clk_i); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].srst, vecs[i].en, vecs[i].addr, vecs[i].ack);
            @(posedge clk_i); #1;
            chk({vecs[i].name, ".val"}, int'(bus.empty_addr_val_o), int'(vecs[i].e_val));
            if (vecs[i].e_val)
                chk({vecs[i].name, ".addr"}, int'(bus.empty_addr_o), int'(vecs[i].e_addr));
            chk({vecs[i].name, ".cnt"}, int'(bus.free_cnt_o), vecs[i].e_cnt);
            chk({vecs[i].name, ".done"}, int'(bus.init_done_o), int'(vecs[i].e_done));
            chk({vecs[i].name, ".dbl"}, int'(bus.dbl_free_err_o), int'(vecs[i].e_dbl));
            chk({vecs[i].name, ".ovf"}, int'(bus.overflow_err_o), 0);
        end

        // random traffic against a queue scoreboard
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        begin
            int waited = 0;
            while (!bus.init_done_o && waited < 20) begin
                @(posedge clk_i); #1;
                waited++;
            end
            chk("init_timeout", int'(bus.init_done_o), 1);
        end
        sb.delete();
        for (int i = 0; i < N; i++) sb.push_back(AW'(i));
        m_mask = '1;
        m_dbl  = 1'b0;
        m_ovf  = 1'b0;

        for (int c = 0; c < 300; c++) begin
            logic          en, ack, pop, dbl, ovf;
            logic [AW-1:0] a;
            en  = ($urandom_range(0, 99) < 50);
            ack = ($urandom_range(0, 99) < 45);
            a   = AW'($urandom_range(0, N - 1));
            chk("sb_val", int'(bus.empty_addr_val_o), int'(sb.size() != 0));
            pop = ack && (sb.size() != 0);
            if (pop) chk("sb_head", int'(bus.empty_addr_o), int'(sb[0]));
            dbl = en && m_mask[a] && !(pop && sb[0] == a);
            ovf = en && !dbl && (sb.size() == N) && !pop;
            if (pop) begin
                m_mask[sb[0]] = 1'b0;
                void'(sb.pop_front());
            end
            if (en && !dbl && !ovf) begin
                sb.push_back(a);
                m_mask[a] = 1'b1;
            end
            m_dbl = m_dbl | dbl;
            m_ovf = m_ovf | ovf;
            drive(1'b0, 1'b0, en, a, ack);
            @(posedge clk_i); #1;
            chk("sb_cnt", int'(bus.free_cnt_o), sb.size());
            chk("sb_dbl", int'(bus.dbl_free_err_o), int'(m_dbl));
            chk("sb_ovf", int'(bus.overflow_err_o), int'(m_ovf));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
